// File: rtl/perf_event_counter_bank_if.sv
// Bus bundle for the performance counter bank: control strobes, event inputs,
// the registered read port and the status flags.
interface perf_event_counter_bank_if #(
    parameter int NUM_EVT = 6,
    parameter int CNT_W   = 32,
    parameter int SEL_W   = 4
);
    logic               start;
    logic               clear;
    logic               halt;
    logic [NUM_EVT-1:0] evt;
    logic               rd_en;
    logic [SEL_W-1:0]   rd_sel;
    logic [CNT_W-1:0]   rd_data;
    logic               rd_valid;
    logic [NUM_EVT:0]   ovf;
    logic               running;
    logic               done;

    modport master (
        output start, clear, halt, evt, rd_en, rd_sel,
        input  rd_data, rd_valid, ovf, running, done
    );

    modport slave (
        input  start, clear, halt, evt, rd_en, rd_sel,
        output rd_data, rd_valid, ovf, running, done
    );
endinterface

// File: rtl/perf_event_counter_bank.sv
// Performance-monitor counter bank: NUM_EVT event counters plus a cycle counter,
// counting over a start-to-halt window, frozen on halt, read through a registered port.
module perf_event_counter_bank #(
    parameter int NUM_EVT  = 6,
    parameter int CNT_W    = 32,
    parameter int SATURATE = 1,
    parameter int SEL_W    = 4
) (
    input logic                      clk,
    input logic                      rst,
    perf_event_counter_bank_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } stateT;

    stateT            stateQ;
    stateT            stateD;
    logic [CNT_W-1:0] cnt [NUM_EVT+1];
    logic [NUM_EVT:0] ovfQ;
    logic [NUM_EVT:0] incVec;
    logic [CNT_W-1:0] rdMux;
    logic [CNT_W-1:0] rdData_p1;
    logic             vld_p1;

    // An all-ones counter either sticks or wraps to zero on its next increment.
    function automatic logic [CNT_W-1:0] bumpCount(input logic [CNT_W-1:0] val);
        if (&val) begin
            return (SATURATE != 0) ? val : '0;
        end
        return val + CNT_W'(1);
    endfunction

    // The top slot is the cycle counter, which ticks on every RUN cycle.
    assign incVec = {1'b1, bus.evt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        if (bus.clear) begin
            stateD = IDLE;
        end else begin
            case (stateQ)
                IDLE:    if (bus.start) stateD = RUN;
                RUN:     if (bus.halt)  stateD = FROZEN;
                FROZEN:  if (bus.start) stateD = RUN;
                default: stateD = IDLE;
            endcase
        end
    end

    // Counting keys off the current state, so the start cycle is skipped and the halt cycle is included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NUM_EVT; i++) cnt[i] <= '0;
            ovfQ <= '0;
        end else if (bus.clear) begin
            for (int i = 0; i <= NUM_EVT; i++) cnt[i] <= '0;
            ovfQ <= '0;
        end else if (stateQ == RUN) begin
            for (int i = 0; i <= NUM_EVT; i++) begin
                if (incVec[i]) begin
                    cnt[i] <= bumpCount(cnt[i]);
                    if (&cnt[i]) ovfQ[i] <= 1'b1;
                end
            end
        end
    end

    // Selects past the cycle counter read as zero.
    always_comb begin
        rdMux = '0;
        for (int i = 0; i <= NUM_EVT; i++) begin
            if (bus.rd_sel == SEL_W'(i)) rdMux = cnt[i];
        end
    end

    // ---- read stage p1 ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdData_p1 <= '0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= bus.rd_en;
            if (bus.rd_en) rdData_p1 <= rdMux;
        end
    end

    assign bus.rd_data  = rdData_p1;
    assign bus.rd_valid = vld_p1;
    assign bus.ovf      = ovfQ;
    assign bus.running  = (stateQ == RUN);
    assign bus.done     = (stateQ == FROZEN);
endmodule
